line_animation_sequencer: RTL and testbench
===========================================

// Module: line_animation_sequencer
// PURPOSE
//  Parametrised animation controller that steps a line drawer through a table of
//  segments. Sits between an external segment ROM and the line_drawer/VGA_framebuffer
//  pair. Adds three things: a column-sweep screen clear, optional erase of the previous
//  segment, and loop/one-shot/ping-pong sequencing. Uses a start/done handshake with the
//  drawer in place of a fixed reset-pulse schedule.
// PARAMETERS
//  X_W          10          x coordinate width
//  Y_W          9           y coordinate width
//  SCREEN_W     640         columns swept by clear (x = 0..SCREEN_W-1)
//  SCREEN_H     480         clear line runs y=0..SCREEN_H-1
//  NUM_SEGS     10          table depth, >=1; IDX_W = max(1,$clog2(NUM_SEGS))
//  HOLD_CYCLES  25_000_000  cycles a segment stays shown before advancing, >=1
// PORTS
//  clk         in   1              single clock
//  reset       in   1              synchronous, active-high
//  run         in   1              level; 0 freezes hold timer (in-flight draw completes)
//  clear       in   1              one-cycle pulse; start screen clear
//  mode        in   2              0 loop, 1 one-shot, 2 ping-pong, 3 treated as loop
//  erase_prev  in   1              1: redraw segment in black before advancing
//  seg_addr    out  IDX_W          ROM address
//  seg_data    in   2*(X_W+Y_W)    {x0,y0,x1,y1}, valid 1 cycle after seg_addr
//  drw_start   out  1              one-cycle pulse to line drawer
//  drw_done    in   1              one-cycle pulse, drawer finished
//  x0,x1       out  X_W            line endpoints to drawer
//  y0,y1       out  Y_W
//  color       out  1              pixel colour, 1 white, 0 black
//  busy        out  1              1 in any state but IDLE/FINISHED
//  done        out  1              high in FINISHED (one-shot complete)
//  cur_index   out  IDX_W          index of segment on screen
// BEHAVIOUR
//  Reset: state IDLE, all coords/seg_addr/cur_index 0, color 0, drw_start/busy/done 0,
//   dir up, hold count 0. Reset wins over every other input in the same cycle.
//  FSM: IDLE -run-> FETCH; FETCH (drive seg_addr) -> LATCH (register seg_data into
//   x0..y1, color=1) -> DRAW (drw_start=1 for exactly this cycle) -> WAIT_DRAW
//   -drw_done-> HOLD. HOLD counts while run=1. After HOLD_CYCLES counted cycles:
//   erase_prev=1 -> ERASE (color=0, drw_start pulse, same coords) -> WAIT_ERASE -drw_done->
//   ADVANCE; erase_prev=0 -> ADVANCE. ADVANCE updates index/dir -> FETCH, or -> FINISHED.
//  Coordinates and color are stable from the drw_start cycle until drw_done.
//   drw_done outside WAIT_* is ignored. drw_done in the same cycle as drw_start is ignored.
//  Index stepping: loop wraps N-1 -> 0. One-shot stops after N-1 is held/erased and
//   enters FINISHED (done=1); leaves it only on clear or reset. Ping-pong:
//   0..N-1, N-2..0, 1.. with no endpoint repeat. NUM_SEGS=1 holds index 0 in all modes.
//   mode is sampled only in ADVANCE.
//  CLEAR: entered on clear from any state, aborting any in-flight draw. A clear during
//   CLEAR restarts at x=0. For col = 0..SCREEN_W-1: x0=x1=col, y0=0, y1=SCREEN_H-1,
//   color=0, drw_start pulse, wait drw_done. After the last column: index=0, dir up,
//   hold count 0, then -> IDLE if run=0, -> FETCH if run=1.
//  run=0: HOLD count frozen. Other states proceed. IDLE waits for run=1.
//  Widths: hold counter $clog2(HOLD_CYCLES+1) bits. Clear column counter X_W bits.
//   No value wider than its port is ever driven.
// STRUCTURE
//  anim_pkg: state_t enum, mode_t enum (MODE_LOOP, MODE_ONESHOT, MODE_PINGPONG),
//   seg_t packed struct {x0,y0,x1,y1} parametrised by X_W/Y_W defaults.
//  Sub-module anim_index_stepper: combinational next-index/next-dir/last flag from
//   (index, dir, mode, NUM_SEGS). Top holds the FSM, hold timer and clear-column counter.
// TESTING  (bench: NUM_SEGS=4, HOLD_CYCLES=8, SCREEN_W=16, SCREEN_H=8; drawer model
//   returns drw_done 3 cycles after drw_start; ROM entry i = {i,i,i+1,i+1})
//  loop, erase_prev=0, run=1 -> cur_index 0,1,2,3,0,1; 8 held cycles between each
//   drw_done and the next FETCH; color=1 on every drw_start.
//  ping-pong -> index sequence 0,1,2,3,2,1,0,1; no endpoint repeated.
//  one-shot, erase_prev=1 -> 4 white + 4 black draws; then done=1, busy=0, no further
//   drw_start for 100 cycles.
//  clear pulse mid WAIT_DRAW -> next drw_start has x0=x1=0, y0=0, y1=7, color=0;
//   16 column draws; then index 0 refetched.
//  run dropped for 20 cycles in HOLD -> advance delayed by exactly 20 cycles.
//  reset asserted in WAIT_ERASE -> next cycle all outputs at reset values.
//   Also: reset and clear asserted together -> IDLE.

Source files
------------

// File: rtl/line_animation_sequencer_pkg.sv
// Shared types for the line animation sequencer: FSM state codes, play modes
// and the segment record layout stored in the external ROM.
package anim_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_FETCH      = 4'd1,
        ST_LATCH      = 4'd2,
        ST_DRAW       = 4'd3,
        ST_WAIT_DRAW  = 4'd4,
        ST_HOLD       = 4'd5,
        ST_ERASE      = 4'd6,
        ST_WAIT_ERASE = 4'd7,
        ST_ADVANCE    = 4'd8,
        ST_FINISHED   = 4'd9,
        ST_CLR_DRAW   = 4'd10,
        ST_CLR_WAIT   = 4'd11
    } state_t;

    // Code 3 is not listed; anything that is not one-shot or ping-pong plays as a loop.
    typedef enum logic [1:0] {
        MODE_LOOP     = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_PINGPONG = 2'd2
    } mode_t;

    localparam int SEG_X_W = 10;
    localparam int SEG_Y_W = 9;

    typedef struct packed {
        logic [SEG_X_W-1:0] x0;
        logic [SEG_Y_W-1:0] y0;
        logic [SEG_X_W-1:0] x1;
        logic [SEG_Y_W-1:0] y1;
    } seg_t;

endpackage

// File: rtl/line_animation_sequencer_if.sv
// Start/done handshake plus endpoint/colour bus between the sequencer and the line drawer.
interface line_animation_sequencer_if #(
    parameter int X_W = 10,
    parameter int Y_W = 9
);
    logic           drw_start;
    logic           drw_done;
    logic [X_W-1:0] x0;
    logic [X_W-1:0] x1;
    logic [Y_W-1:0] y0;
    logic [Y_W-1:0] y1;
    logic           color;

    modport master (
        output drw_start, x0, y0, x1, y1, color,
        input  drw_done
    );

    modport slave (
        input  drw_start, x0, y0, x1, y1, color,
        output drw_done
    );
endinterface

// File: rtl/line_animation_sequencer_stepper.sv
// Combinational next-index / next-direction logic for loop, one-shot and ping-pong play.
module anim_index_stepper
    import anim_pkg::*;
#(
    parameter int NUM_SEGS = 10,
    parameter int IDX_W    = 4
) (
    input  logic [IDX_W-1:0] index,
    input  logic             dir_up,
    input  logic [1:0]       mode,
    output logic [IDX_W-1:0] next_index,
    output logic             next_dir_up,
    output logic             last
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEGS - 1);

    // Ping-pong turns around at either end without showing the endpoint twice.
    always_comb begin
        next_index  = index;
        next_dir_up = dir_up;
        last        = (index == LAST_IDX);
        if (NUM_SEGS == 1) begin
            next_index  = '0;
            next_dir_up = 1'b1;
        end else if (mode == MODE_PINGPONG) begin
            if (dir_up) begin
                if (index == LAST_IDX) begin
                    next_index  = index - 1'b1;
                    next_dir_up = 1'b0;
                end else begin
                    next_index = index + 1'b1;
                end
            end else begin
                if (index == '0) begin
                    next_index  = IDX_W'(1);
                    next_dir_up = 1'b1;
                end else begin
                    next_index = index - 1'b1;
                end
            end
        end else begin
            next_dir_up = 1'b1;
            next_index  = last ? '0 : index + 1'b1;
        end
    end

endmodule

// File: rtl/line_animation_sequencer.sv
// Steps a line drawer through a ROM table of segments, with optional erase of the
// previous segment and a column-sweep screen clear.
//
//  state      | meaning
//  -----------+-----------------------------------------------------
//  IDLE       | waiting for run
//  FETCH      | seg_addr presented to ROM
//  LATCH      | ROM word captured into endpoints, colour white
//  DRAW       | drw_start pulse for the white segment
//  WAIT_DRAW  | waiting for drw_done
//  HOLD       | segment shown; timer counts while run=1
//  ERASE      | drw_start pulse redrawing the same segment black
//  WAIT_ERASE | waiting for drw_done of the erase
//  ADVANCE    | step index/direction, or finish a one-shot
//  FINISHED   | one-shot complete; only clear or reset leave
//  CLR_DRAW   | drw_start pulse for one black clear column
//  CLR_WAIT   | waiting for drw_done of that column
module line_animation_sequencer
    import anim_pkg::*;
#(
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int NUM_SEGS    = 10,
    parameter int HOLD_CYCLES = 25_000_000,
    localparam int IDX_W      = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   clear,
    input  logic [1:0]             mode,
    input  logic                   erase_prev,
    output logic [IDX_W-1:0]       seg_addr,
    input  logic [2*(X_W+Y_W)-1:0] seg_data,
    line_animation_sequencer_if.master drw,
    output logic                   busy,
    output logic                   done,
    output logic [IDX_W-1:0]       cur_index
);
    localparam int SEG_W = 2 * (X_W + Y_W);
    localparam int HC_W  = $clog2(HOLD_CYCLES + 1);

    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [X_W-1:0]  COL_LAST  = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0]  ROW_LAST  = Y_W'(SCREEN_H - 1);

    localparam logic [3:0] S_IDLE       = ST_IDLE;
    localparam logic [3:0] S_FETCH      = ST_FETCH;
    localparam logic [3:0] S_LATCH      = ST_LATCH;
    localparam logic [3:0] S_DRAW       = ST_DRAW;
    localparam logic [3:0] S_WAIT_DRAW  = ST_WAIT_DRAW;
    localparam logic [3:0] S_HOLD       = ST_HOLD;
    localparam logic [3:0] S_ERASE      = ST_ERASE;
    localparam logic [3:0] S_WAIT_ERASE = ST_WAIT_ERASE;
    localparam logic [3:0] S_ADVANCE    = ST_ADVANCE;
    localparam logic [3:0] S_FINISHED   = ST_FINISHED;
    localparam logic [3:0] S_CLR_DRAW   = ST_CLR_DRAW;
    localparam logic [3:0] S_CLR_WAIT   = ST_CLR_WAIT;

    logic [3:0]       state;
    logic [IDX_W-1:0] idx;
    logic             dir_up;
    logic [HC_W-1:0]  hold_cnt;
    logic [X_W-1:0]   col;
    logic [X_W-1:0]   x0_q, x1_q;
    logic [Y_W-1:0]   y0_q, y1_q;
    logic             color_q;

    logic [IDX_W-1:0] next_idx;
    logic             next_dir_up;
    logic             last_seg;

    anim_index_stepper #(
        .NUM_SEGS (NUM_SEGS),
        .IDX_W    (IDX_W)
    ) u_step (
        .index       (idx),
        .dir_up      (dir_up),
        .mode        (mode),
        .next_index  (next_idx),
        .next_dir_up (next_dir_up),
        .last        (last_seg)
    );

    // Sequencer FSM; reset beats clear, clear beats everything else and aborts any draw.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            dir_up   <= 1'b1;
            hold_cnt <= '0;
            col      <= '0;
            x0_q     <= '0;
            x1_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            color_q  <= 1'b0;
        end else if (clear) begin
            state   <= S_CLR_DRAW;
            col     <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= ROW_LAST;
            color_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) state <= S_FETCH;
                end
                S_FETCH: state <= S_LATCH;
                S_LATCH: begin
                    x0_q    <= seg_data[SEG_W-1 -: X_W];
                    y0_q    <= seg_data[X_W+2*Y_W-1 -: Y_W];
                    x1_q    <= seg_data[X_W+Y_W-1 -: X_W];
                    y1_q    <= seg_data[Y_W-1:0];
                    color_q <= 1'b1;
                    state   <= S_DRAW;
                end
                S_DRAW: state <= S_WAIT_DRAW;
                S_WAIT_DRAW: begin
                    if (drw.drw_done) state <= S_HOLD;
                end
                S_HOLD: begin
                    if (run) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            if (erase_prev) begin
                                color_q <= 1'b0;
                                state   <= S_ERASE;
                            end else begin
                                state <= S_ADVANCE;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                S_ERASE: state <= S_WAIT_ERASE;
                S_WAIT_ERASE: begin
                    if (drw.drw_done) state <= S_ADVANCE;
                end
                S_ADVANCE: begin
                    if ((mode == MODE_ONESHOT) && last_seg) begin
                        state <= S_FINISHED;
                    end else begin
                        idx    <= next_idx;
                        dir_up <= next_dir_up;
                        state  <= S_FETCH;
                    end
                end
                S_FINISHED: state <= S_FINISHED;
                S_CLR_DRAW: state <= S_CLR_WAIT;
                S_CLR_WAIT: begin
                    if (drw.drw_done) begin
                        if (col == COL_LAST) begin
                            idx      <= '0;
                            dir_up   <= 1'b1;
                            hold_cnt <= '0;
                            state    <= run ? S_FETCH : S_IDLE;
                        end else begin
                            col   <= col + 1'b1;
                            x0_q  <= col + 1'b1;
                            x1_q  <= col + 1'b1;
                            state <= S_CLR_DRAW;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign drw.drw_start = (state == S_DRAW) || (state == S_ERASE) || (state == S_CLR_DRAW);
    assign drw.x0        = x0_q;
    assign drw.x1        = x1_q;
    assign drw.y0        = y0_q;
    assign drw.y1        = y1_q;
    assign drw.color     = color_q;

    assign seg_addr  = idx;
    assign cur_index = idx;
    assign busy      = (state != S_IDLE) && (state != S_FINISHED);
    assign done      = (state == S_FINISHED);

endmodule

// File: tb/tb_line_animation_sequencer.sv
// Bench for line_animation_sequencer: drawer responder, registered ROM, and a
// draw-level model (queue of expected drw_start events) checked every cycle.
module tb_line_animation_sequencer;
    localparam int X_W         = 10;
    localparam int Y_W         = 9;
    localparam int SCREEN_W    = 16;
    localparam int SCREEN_H    = 8;
    localparam int NUM_SEGS    = 4;
    localparam int HOLD_CYCLES = 8;
    localparam int IDX_W       = 2;
    localparam int DRAW_LAT    = 3;

    // Draw-to-draw spacing from the FSM walk: done, HOLD_CYCLES held, then
    // ADVANCE, FETCH, LATCH before the next DRAW.
    localparam int GAP_NEXT        = DRAW_LAT + 1 + HOLD_CYCLES + 3;
    localparam int GAP_ERASE       = DRAW_LAT + 1 + HOLD_CYCLES;
    localparam int GAP_AFTER_ERASE = DRAW_LAT + 1 + 3;
    localparam int GAP_CLR_ABORT   = 2;
    localparam int GAP_CLR_COL     = DRAW_LAT + 1;
    localparam int GAP_CLR_DONE    = DRAW_LAT + 3;

    typedef struct {
        int x0, y0, x1, y1;
        int color;
        int idx;
        int gap;
    } draw_t;

    logic                   clk;
    logic                   reset, run, clear, erase_prev;
    logic [1:0]             mode;
    logic [IDX_W-1:0]       seg_addr, cur_index;
    logic [2*(X_W+Y_W)-1:0] seg_data;
    logic                   busy, done;

    line_animation_sequencer_if #(.X_W(X_W), .Y_W(Y_W)) drw_if ();

    line_animation_sequencer #(
        .X_W         (X_W),
        .Y_W         (Y_W),
        .SCREEN_W    (SCREEN_W),
        .SCREEN_H    (SCREEN_H),
        .NUM_SEGS    (NUM_SEGS),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .clear      (clear),
        .mode       (mode),
        .erase_prev (erase_prev),
        .seg_addr   (seg_addr),
        .seg_data   (seg_data),
        .drw        (drw_if),
        .busy       (busy),
        .done       (done),
        .cur_index  (cur_index)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_start = 0;
    int last_gap = 0;
    int n_starts = 0;
    int dcnt = 0;
    int base = 0;
    bit inflight = 0;
    draw_t exp_q[$];
    draw_t cur_exp;
    logic [X_W-1:0] lx0, lx1;
    logic [Y_W-1:0] ly0, ly1;
    logic           lcolor;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [2*(X_W+Y_W)-1:0] rom_word(input int i);
        logic [X_W-1:0] a, c;
        logic [Y_W-1:0] b, d;
        a = X_W'(i);
        b = Y_W'(i);
        c = X_W'(i + 1);
        d = Y_W'(i + 1);
        return {a, b, c, d};
    endfunction

    function automatic draw_t seg_draw(input int i, input int color, input int gap);
        draw_t d;
        d.x0 = i; d.y0 = i; d.x1 = i + 1; d.y1 = i + 1;
        d.color = color; d.idx = i; d.gap = gap;
        return d;
    endfunction

    function automatic draw_t col_draw(input int c, input int gap);
        draw_t d;
        d.x0 = c; d.y0 = 0; d.x1 = c; d.y1 = SCREEN_H - 1;
        d.color = 0; d.idx = -1; d.gap = gap;
        return d;
    endfunction

    function automatic int pingpong_idx(input int k);
        int p;
        p = k % (2 * NUM_SEGS - 2);
        return (p < NUM_SEGS) ? p : (2 * NUM_SEGS - 2 - p);
    endfunction

    // Segment ROM: data valid the cycle after the address.
    always @(posedge clk) seg_data <= rom_word(int'(seg_addr));

    // Line drawer model: drw_done pulses DRAW_LAT cycles after the latest drw_start.
    always @(posedge clk) begin
        if (reset) begin
            dcnt <= 0;
            drw_if.drw_done <= 1'b0;
        end else if (drw_if.drw_start) begin
            dcnt <= DRAW_LAT - 1;
            drw_if.drw_done <= 1'b0;
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            drw_if.drw_done <= (dcnt == 1);
        end else begin
            drw_if.drw_done <= 1'b0;
        end
    end

    // Compare process: every drw_start must match the next expected draw; endpoints
    // and colour must stay put until the drawer reports done.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            inflight = 0;
        end else if (drw_if.drw_start) begin
            chk("start_expected", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                cur_exp = exp_q.pop_front();
                chk("x0", longint'(drw_if.x0), cur_exp.x0);
                chk("y0", longint'(drw_if.y0), cur_exp.y0);
                chk("x1", longint'(drw_if.x1), cur_exp.x1);
                chk("y1", longint'(drw_if.y1), cur_exp.y1);
                chk("color", longint'(drw_if.color), cur_exp.color);
                if (cur_exp.idx >= 0) chk("cur_index", longint'(cur_index), cur_exp.idx);
                if (cur_exp.gap > 0) chk("start_gap", cyc - last_start, cur_exp.gap);
            end
            last_gap   = cyc - last_start;
            last_start = cyc;
            n_starts++;
            lx0 = drw_if.x0; ly0 = drw_if.y0; lx1 = drw_if.x1; ly1 = drw_if.y1;
            lcolor = drw_if.color;
            inflight = 1;
        end else if (inflight) begin
            chk("stable_during_draw",
                longint'({drw_if.x0, drw_if.y0, drw_if.x1, drw_if.y1, drw_if.color}),
                longint'({lx0, ly0, lx1, ly1, lcolor}));
            if (drw_if.drw_done) inflight = 0;
        end
    end

    task automatic wait_starts(input int k, input int budget);
        int n;
        n = 0;
        while (n_starts < k && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("wait_starts", n_starts, k);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; run = 1'b0; clear = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_seg_addr"}, longint'(seg_addr), 0);
        chk({tag, "_drw_start"}, longint'(drw_if.drw_start), 0);
        chk({tag, "_x0"}, longint'(drw_if.x0), 0);
        chk({tag, "_y0"}, longint'(drw_if.y0), 0);
        chk({tag, "_x1"}, longint'(drw_if.x1), 0);
        chk({tag, "_y1"}, longint'(drw_if.y1), 0);
        chk({tag, "_color"}, longint'(drw_if.color), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_cur_index"}, longint'(cur_index), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        int n;
        reset = 1'b1; run = 1'b0; clear = 1'b0; mode = 2'd0; erase_prev = 1'b0;
        do_reset();
        check_reset_outputs("reset");

        // Loop, no erase.
        base = n_starts;
        for (int k = 0; k < 6; k++)
            exp_q.push_back(seg_draw(k % NUM_SEGS, 1, (k == 0) ? 0 : GAP_NEXT));
        mode = 2'd0; erase_prev = 1'b0; run = 1'b1;
        wait_starts(base + 6, 200);
        chk("pin_loop_gap", last_gap, 15);
        chk("pin_loop_x1", longint'(lx1), 2);
        chk("loop_drained", exp_q.size(), 0);
        do_reset();

        // Ping-pong.
        base = n_starts;
        for (int k = 0; k < 8; k++)
            exp_q.push_back(seg_draw(pingpong_idx(k), 1, (k == 0) ? 0 : GAP_NEXT));
        mode = 2'd2; run = 1'b1;
        wait_starts(base + 8, 250);
        chk("pin_pp_index", longint'(cur_index), 1);
        chk("pp_drained", exp_q.size(), 0);
        do_reset();

        // One-shot with erase.
        base = n_starts;
        for (int k = 0; k < NUM_SEGS; k++) begin
            exp_q.push_back(seg_draw(k, 1, (k == 0) ? 0 : GAP_AFTER_ERASE));
            exp_q.push_back(seg_draw(k, 0, GAP_ERASE));
        end
        mode = 2'd1; erase_prev = 1'b1; run = 1'b1;
        wait_starts(base + 2 * NUM_SEGS, 300);
        n = 0;
        while (!done && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("oneshot_done", longint'(done), 1);
        chk("oneshot_busy", longint'(busy), 0);
        chk("pin_oneshot_index", longint'(cur_index), 3);
        base = n_starts;
        repeat (100) @(posedge clk);
        chk("oneshot_quiet", n_starts - base, 0);
        chk("oneshot_still_done", longint'(done), 1);
        do_reset();

        // Reset during WAIT_ERASE.
        base = n_starts;
        exp_q.push_back(seg_draw(0, 1, 0));
        exp_q.push_back(seg_draw(0, 0, GAP_ERASE));
        mode = 2'd1; erase_prev = 1'b1; run = 1'b1;
        wait_starts(base + 2, 100);
        #1;
        reset = 1'b1; run = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("rst_in_erase");
        reset = 1'b0;
        exp_q.delete();
        do_reset();

        // Clear mid WAIT_DRAW.
        base = n_starts;
        exp_q.push_back(seg_draw(0, 1, 0));
        for (int c = 0; c < SCREEN_W; c++)
            exp_q.push_back(col_draw(c, (c == 0) ? GAP_CLR_ABORT : GAP_CLR_COL));
        exp_q.push_back(seg_draw(0, 1, GAP_CLR_DONE));
        mode = 2'd0; erase_prev = 1'b0; run = 1'b1;
        wait_starts(base + 1, 50);
        #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        wait_starts(base + 2, 20);
        chk("pin_clear_y1", longint'(ly1), 7);
        chk("pin_clear_color", longint'(lcolor), 0);
        wait_starts(base + SCREEN_W + 2, 200);
        chk("pin_refetch_gap", last_gap, 6);
        chk("clear_drained", exp_q.size(), 0);
        do_reset();

        // run dropped for 20 cycles during HOLD.
        base = n_starts;
        exp_q.push_back(seg_draw(0, 1, 0));
        exp_q.push_back(seg_draw(1, 1, GAP_NEXT + 20));
        mode = 2'd0; erase_prev = 1'b0; run = 1'b1;
        wait_starts(base + 1, 50);
        #1;
        repeat (4) @(posedge clk);
        #1;
        run = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        run = 1'b1;
        wait_starts(base + 2, 100);
        chk("pin_run_drop_gap", last_gap, 35);
        do_reset();

        // reset and clear together.
        base = n_starts;
        exp_q.push_back(seg_draw(0, 1, 0));
        mode = 2'd0; run = 1'b1;
        wait_starts(base + 1, 50);
        #1;
        reset = 1'b1; clear = 1'b1; run = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("rst_clr");
        reset = 1'b0; clear = 1'b0;
        exp_q.delete();
        base = n_starts;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_clr_quiet", n_starts - base, 0);
        chk("rst_clr_busy", longint'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
